core_packetizer: RTL and testbench

- Core-side transmitter that feeds the core/router interface block's from_core_flit/v_from_core inputs.
- Accepts one message descriptor and a stream of payload words from the core, and frames them into head, body and tail flits.
- Injects at most one flit per cycle, and only when the interface's read enable is high and the target VC is not full.
- Sits between the core's message port and the core/router interface, one instance per injection port.

---
 rtl/core_pkt_pkg.sv | 21 ++
 rtl/core_packetizer_if.sv | 32 +++
 rtl/core_packetizer.sv | 106 ++++++++++
 tb/tb_core_packetizer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkt_pkg.sv
// core_pkt_pkg: flit types, FSM states and head-field offsets shared by packetizer/depacketizer
package core_pkt_pkg;
    localparam logic [1:0] FLIT_HEAD   = 2'b00;
    localparam logic [1:0] FLIT_BODY   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    function automatic int dest_lsb(int fw, int db);
        return fw - 2 - db;
    endfunction

    function automatic int vc_lsb(int fw, int db, int vb);
        return fw - 2 - db - vb;
    endfunction

    function automatic int len_lsb(int fw, int db, int vb, int lb);
        return fw - 2 - db - vb - lb;
    endfunction
endpackage

// File: rtl/core_packetizer_if.sv
// core_packetizer_if: message, payload-word and flit-injection signals of one injection port
interface core_packetizer_if #(
    parameter int FLIT_WIDTH      = 32,
    parameter int VC_PER_IN_PORTS = 2,
    parameter int VC_BITS         = 1,
    parameter int DEST_BITS       = 4,
    parameter int LEN_BITS        = 5
);
    logic                       msg_valid;
    logic                       msg_ready;
    logic [DEST_BITS-1:0]       msg_dest;
    logic [VC_BITS-1:0]         msg_vc;
    logic [LEN_BITS-1:0]        msg_len;
    logic [FLIT_WIDTH-3:0]      word_in;
    logic                       word_valid;
    logic                       word_ready;
    logic                       REn;
    logic [VC_PER_IN_PORTS-1:0] vc_full;
    logic [FLIT_WIDTH-1:0]      flit_out;
    logic                       v_flit_out;
    logic                       busy;

    modport master (
        output msg_valid, msg_dest, msg_vc, msg_len, word_in, word_valid, REn, vc_full,
        input  msg_ready, word_ready, flit_out, v_flit_out, busy
    );

    modport slave (
        input  msg_valid, msg_dest, msg_vc, msg_len, word_in, word_valid, REn, vc_full,
        output msg_ready, word_ready, flit_out, v_flit_out, busy
    );
endinterface

// File: rtl/core_packetizer.sv
// core_packetizer: frames a descriptor plus payload words into head/body/tail flits; CORE_PKT_SEQ_EN adds an 8-bit head sequence number
module core_packetizer
    import core_pkt_pkg::*;
#(
    parameter int FLIT_WIDTH      = 32,
    parameter int VC_PER_IN_PORTS = 2,
    parameter int VC_BITS         = 1,
    parameter int DEST_BITS       = 4,
    parameter int LEN_BITS        = 5
) (
    input logic              clk,
    input logic              reset,
    core_packetizer_if.slave bus
);
`ifdef CORE_PKT_SEQ_EN
    localparam int SEQ_BITS = 8;
`else
    localparam int SEQ_BITS = 0;
`endif
    localparam int DL = dest_lsb(FLIT_WIDTH, DEST_BITS);
    localparam int VL = vc_lsb(FLIT_WIDTH, DEST_BITS, VC_BITS);
    localparam int LL = len_lsb(FLIT_WIDTH, DEST_BITS, VC_BITS, LEN_BITS);

    generate
        if (DEST_BITS + VC_BITS + LEN_BITS + SEQ_BITS > FLIT_WIDTH - 2) begin : g_bad_fields
            $error("core_packetizer: head fields do not fit in FLIT_WIDTH-2 bits");
        end
        if (VC_BITS != $clog2(VC_PER_IN_PORTS)) begin : g_bad_vc_bits
            $error("core_packetizer: VC_BITS must equal clog2(VC_PER_IN_PORTS)");
        end
    endgenerate

    state_t                state;
    logic [DEST_BITS-1:0]  dest_r;
    logic [VC_BITS-1:0]    vc_r;
    logic [LEN_BITS-1:0]   len_r;
    logic [LEN_BITS-1:0]   count;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  v_q;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  go;
`ifdef CORE_PKT_SEQ_EN
    logic [7:0]            seq;
`endif

    assign go             = bus.REn & ~bus.vc_full[vc_r];
    assign bus.msg_ready  = state == S_IDLE;
    assign bus.busy       = state != S_IDLE;
    assign bus.word_ready = (state == S_BODY) & go;
    assign bus.flit_out   = flit_q;
    assign bus.v_flit_out = v_q;

    // head/single flit assembled from the latched descriptor
    always_comb begin
        head_flit = '0;
        head_flit[FLIT_WIDTH-1 -: 2] = (len_r == '0) ? FLIT_SINGLE : FLIT_HEAD;
        head_flit[DL +: DEST_BITS] = dest_r;
        head_flit[VL +: VC_BITS] = vc_r;
        head_flit[LL +: LEN_BITS] = len_r;
`ifdef CORE_PKT_SEQ_EN
        head_flit[7:0] = seq;
`endif
    end

    // framing FSM with registered flit output; idle cycles drop valid but hold the flit
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            count  <= '0;
            flit_q <= '0;
            v_q    <= 1'b0;
            dest_r <= '0;
            vc_r   <= '0;
            len_r  <= '0;
`ifdef CORE_PKT_SEQ_EN
            seq    <= '0;
`endif
        end else begin
            v_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.msg_valid) begin
                    dest_r <= bus.msg_dest;
                    vc_r   <= bus.msg_vc;
                    len_r  <= bus.msg_len;
                    count  <= bus.msg_len;
                    state  <= S_HEAD;
                end
                S_HEAD: if (go) begin
                    flit_q <= head_flit;
                    v_q    <= 1'b1;
                    state  <= (len_r == '0) ? S_IDLE : S_BODY;
`ifdef CORE_PKT_SEQ_EN
                    seq    <= seq + 8'd1;
`endif
                end
                S_BODY: if (go && bus.word_valid) begin
                    flit_q <= {(count == LEN_BITS'(1)) ? FLIT_TAIL : FLIT_BODY, bus.word_in};
                    v_q    <= 1'b1;
                    count  <= count - LEN_BITS'(1);
                    state  <= (count == LEN_BITS'(1)) ? S_IDLE : S_BODY;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_packetizer.sv
// tb_core_packetizer: randomized scoreboard bench for core_packetizer (honours CORE_PKT_SEQ_EN)
module tb_core_packetizer;
    localparam int FW = 32;
    localparam int NV = 2;
    localparam int VB = 1;
    localparam int DB = 4;
    localparam int LB = 5;

    typedef struct {
        logic [FW-1:0] flit;
        int            gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_packetizer_if #(.FLIT_WIDTH(FW), .VC_PER_IN_PORTS(NV), .VC_BITS(VB), .DEST_BITS(DB), .LEN_BITS(LB)) bus();

    core_packetizer #(.FLIT_WIDTH(FW), .VC_PER_IN_PORTS(NV), .VC_BITS(VB), .DEST_BITS(DB), .LEN_BITS(LB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_cyc = -100;
    logic [7:0] seq_m = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [FW-1:0] head_word(int dest, int vc, int len, logic [7:0] s);
        logic [FW-1:0] h;
        h = (FW'(len == 0 ? 3 : 0) << (FW - 2)) | (FW'(dest) << (FW - 2 - DB))
          | (FW'(vc) << (FW - 2 - DB - VB)) | (FW'(len) << (FW - 2 - DB - VB - LB));
`ifdef CORE_PKT_SEQ_EN
        h = h | FW'(s);
`endif
        return h;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // scoreboard monitor: every presented flit must match the oldest expected one
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.v_flit_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %h, required no flit", bus.flit_out);
            end else begin
                e = q.pop_front();
                if (bus.flit_out !== e.flit) begin
                    errors++;
                    $display("FAIL flit: got %h, required %h", bus.flit_out, e.flit);
                end
                if (e.gap >= 0) begin
                    checks++;
                    if (cyc - last_cyc != e.gap) begin
                        errors++;
                        $display("FAIL flit_gap: got %0d cycles, required %0d", cyc - last_cyc, e.gap);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    // mode 0 clean, 1 random, 2 stall vc0 for 4 cycles after head, 3 REn 1-0-1 and word_valid gap
    task automatic send_msg(input int dest, input int vc, input int len, input int mode, input int head_gap, input bit fixed);
        logic [FW-3:0] w[32];
        bit acc, fire;
        int n, k, it;
        for (int i = 0; i < len; i++) w[i] = fixed ? (FW-2)'(i + 1) : (FW-2)'($urandom);
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            bus.msg_valid = 1'b1;
            bus.msg_dest = DB'(dest);
            bus.msg_vc = VB'(vc);
            bus.msg_len = LB'(len);
            bus.word_valid = (mode == 1) ? 1'($urandom) : 1'b0;
            bus.REn = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.vc_full = (mode == 1) ? NV'($urandom) & NV'($urandom) : '0;
            #1;
            acc = bus.msg_ready;
            if (bus.msg_ready) check("word_ready_idle", FW'(bus.word_ready), '0);
            @(posedge clk);
            if (!acc && ++n > 2000) begin
                errors++;
                $display("FAIL accept_timeout: got no msg_ready, required acceptance");
                return;
            end
        end
        q.push_back('{head_word(dest, vc, len, seq_m), head_gap});
        seq_m++;
        for (int i = 0; i < len; i++)
            q.push_back('{{(i == len - 1) ? 2'b10 : 2'b01, w[i]},
                          (mode == 0) ? 1 : (mode == 2) ? ((i == 0) ? 5 : 1) : -1});
        k = 0;
        it = 0;
        while (k < len) begin
            @(negedge clk);
            bus.msg_valid = 1'b0;
            bus.msg_dest = DB'($urandom);
            bus.msg_vc = VB'($urandom);
            bus.msg_len = LB'($urandom);
            bus.word_in = w[k];
            case (mode)
                1: begin
                    bus.REn = $urandom_range(0, 3) != 0;
                    bus.vc_full = NV'($urandom) & NV'($urandom);
                    bus.word_valid = $urandom_range(0, 3) != 0;
                end
                2: begin
                    bus.REn = 1'b1;
                    bus.vc_full = {1'($urandom), (it >= 1 && it <= 4)};
                    bus.word_valid = 1'b1;
                end
                3: begin
                    bus.REn = it != 2;
                    bus.vc_full = '0;
                    bus.word_valid = !(it == 3 || it == 4);
                end
                default: begin
                    bus.REn = 1'b1;
                    bus.vc_full = '0;
                    bus.word_valid = 1'b1;
                end
            endcase
            #1;
            if (!bus.REn) check("word_ready_ren0", FW'(bus.word_ready), '0);
            fire = bus.word_valid && bus.word_ready;
            @(posedge clk);
            if (fire) k++;
            if (++it > 5000) begin
                errors++;
                $display("FAIL word_timeout: got %0d words consumed, required %0d", k, len);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.msg_valid = 1'b0;
            bus.word_valid = 1'b0;
            bus.REn = 1'b1;
            bus.vc_full = '0;
            #1;
            done = !bus.busy && q.size() == 0;
            @(posedge clk);
            if (!done && ++n > 200) begin
                errors++;
                $display("FAIL drain_timeout: got %0d flits pending busy=%0b, required 0", q.size(), bus.busy);
                q.delete();
                done = 1'b1;
            end
        end
    endtask

    initial begin
        logic [FW-3:0] w0;
        bus.msg_valid = 1'b0;
        bus.msg_dest = '0;
        bus.msg_vc = '0;
        bus.msg_len = '0;
        bus.word_in = '0;
        bus.word_valid = 1'b0;
        bus.REn = 1'b0;
        bus.vc_full = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_v_flit_out", FW'(bus.v_flit_out), '0);
        check("rst_flit_out", bus.flit_out, '0);
        check("rst_msg_ready", FW'(bus.msg_ready), FW'(1));
        check("rst_busy", FW'(bus.busy), '0);
        check("rst_word_ready", FW'(bus.word_ready), '0);
        reset = 1'b1;
        @(posedge clk);

        send_msg(5, 1, 0, 0, -1, 1'b0);
        drain();
        check("busy_after_single", FW'(bus.busy), '0);
        send_msg(2, 0, 3, 0, -1, 1'b1);
        drain();
        send_msg(2, 0, 3, 2, -1, 1'b0);
        drain();
        send_msg(9, 1, 5, 3, -1, 1'b0);
        drain();

        w0 = (FW-2)'($urandom);
        q.push_back('{head_word(3, 0, 3, seq_m), -1});
        q.push_back('{{2'b01, w0}, 1});
        @(negedge clk);
        bus.msg_valid = 1'b1;
        bus.msg_dest = DB'(3);
        bus.msg_vc = VB'(0);
        bus.msg_len = LB'(3);
        @(posedge clk);
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_in = w0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        bus.word_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_v_flit_out", FW'(bus.v_flit_out), '0);
        check("abort_flit_out", bus.flit_out, '0);
        check("abort_pending", FW'(q.size()), '0);
        q.delete();
        seq_m = 8'd0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_msg_ready", FW'(bus.msg_ready), FW'(1));
        check("post_rst_busy", FW'(bus.busy), '0);
        @(posedge clk);

        send_msg(1, 0, 1, 0, -1, 1'b0);
        send_msg(4, 1, 1, 0, 2, 1'b0);
        drain();

        for (int m = 0; m < 300; m++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 31) : $urandom_range(0, 31);
            send_msg($urandom_range(0, 15), $urandom_range(0, 1), len, 1, -1, 1'b0);
        end
        drain();
        check("final_busy", FW'(bus.busy), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
